truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises a 4-input combinational function block (X, Y, W, Z -> S) through all 16 input combinations (M = 0..15), in index order. It captures the response into a 16-bit truth-table vector and compares it against an expected maxterm mask. It sits between a 4-input sum-of-products/product-of-sums evaluator and the control/status logic, replacing hand-written stimulus sequences with a start/done-controlled hardware sweep.

Parameters:
SETTLE_CYCLES, 1, cycles each index is held before the extra sample cycle; legal range 0..15.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  sweep request; sampled only in IDLE
exp_maxterms  input  16  expected maxterm mask; bit i = 1 means S must be 0 at M = i; latched on start accept
S  input  1  response of the function block under test
X  output  1  function input, M[3] (MSB)
Y  output  1  function input, M[2]
W  output  1  function input, M[1]
Z  output  1  function input, M[0] (LSB)
M  output  4  current index; always equals {X,Y,W,Z}
busy  output  1  high from start accept until DONE is left
done  output  1  one-cycle pulse at sweep end
table_out  output  16  captured S per index; bit i = S at M = i
mismatch  output  16  bit i = 1 when captured S differs from ~exp_maxterms[i]
err_cnt  output  5  number of set mismatch bits, 0..16
pass  output  1  high when the last completed sweep had err_cnt == 0

Behaviour:
- Reset (async, rst_n low): state = IDLE; M/X/Y/W/Z = 0; busy = 0; done = 0; table_out = 0; mismatch = 0; err_cnt = 0; pass = 0; latched mask = 0. Reset takes effect immediately, including mid-sweep. A sweep aborted by reset produces no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on a clock edge with start = 1, the block does all of the following:
  - Latches exp_maxterms.
  - Clears table_out, mismatch, err_cnt and pass.
  - Sets M = 0 and busy = 1.
  - Loads the settle counter with SETTLE_CYCLES.
  - Goes to SETTLE, or directly to SAMPLE when SETTLE_CYCLES = 0.
- SETTLE: the counter decrements each cycle; when it reaches 0 the block moves to SAMPLE. M is held constant.
- SAMPLE: lasts one cycle. At its ending edge:
  - table_out[M] <= S.
  - mismatch[M] <= S XOR ~mask[M].
  - err_cnt increments when that mismatch bit is 1.
  - If M = 15, go to DONE. Otherwise M <= M + 1, reload the counter and go to SETTLE (or SAMPLE when SETTLE_CYCLES = 0).
- Timing: each index is presented for exactly SETTLE_CYCLES + 1 cycles. Sampling happens at the last edge of that window, so the function block has at least SETTLE_CYCLES + 1 cycles of combinational settling.
- DONE: lasts one cycle.
  - done = 1 and busy stays 1.
  - pass <= (err_cnt == 0), using the final count.
  - The next state is IDLE, with M <= 0 and busy <= 0.
- done is first high 16*(SETTLE_CYCLES+1) cycles after the start-accept edge.
- Results (table_out, mismatch, err_cnt, pass) hold their values in IDLE until the next start accept.
- start while busy is ignored; no queuing.
- If start is held high continuously, a new sweep is accepted on the first IDLE cycle after DONE (back-to-back sweeps, one IDLE cycle between them).
- Changes to exp_maxterms during a sweep have no effect.
- M wraps only via the DONE -> IDLE reset to 0. M never increments past 15.
- err_cnt saturates naturally at 16, because there are at most 16 samples.
- S is sampled as-is. An unknown S yields unknown table/mismatch bits; benches must drive known values.

Test Plan:
1. Reset check: assert rst_n low with random inputs -> all outputs 0; release with start = 0 -> outputs stay 0 and state stays IDLE.
2. Golden sweep, SETTLE_CYCLES = 1: exp_maxterms = 16'h8396 (M 1,2,4,7,8,9,15), S driven by a correct product-of-sums model of that function.
   -> M steps 0..15, each value held 2 cycles.
   -> done pulses 32 cycles after the start edge.
   -> table_out = 16'h7C69, mismatch = 0, err_cnt = 0, pass = 1.
3. Fault injection: same mask, S stuck at 1.
   -> table_out = 16'hFFFF, mismatch = 16'h8396, err_cnt = 7, pass = 0.
   Repeat with S stuck at 0.
   -> table_out = 16'h0000, mismatch = 16'h7C69, err_cnt = 9, pass = 0.
4. Handshake:
   - Pulse start again at M = 6 -> ignored, sweep is unchanged.
   - Hold start high with the mask changed to 16'h0000 mid-run -> first sweep uses the old mask. After one IDLE cycle a second sweep starts with the new mask, and results are cleared at its accept edge.
5. Reset mid-sweep: drop rst_n while M = 5 -> outputs immediately at reset values, no done pulse. A subsequent start then completes a normal 32-cycle sweep.
6. Parameter sweep: SETTLE_CYCLES = 0 -> each M held 1 cycle, done at 16 cycles. SETTLE_CYCLES = 3 -> each M held 4 cycles, done at 64 cycles. Results are identical to scenario 2.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 4-input function block through M = 0..15,
// captures its response S into a truth-table vector and compares each bit
// against an expected maxterm mask (mask bit set => S must be 0 there).
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] exp_maxterms,
   input  logic        S,
   output logic        X,
   output logic        Y,
   output logic        W,
   output logic        Z,
   output logic [3:0]  M,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic [15:0] mismatch,
   output logic [4:0]  err_cnt,
   output logic        pass
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   // With no settle time every index goes straight to its sample cycle.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   state_t      state;
   logic [3:0]  settle_cnt;
   logic [15:0] mask;
   logic        miss;

   // The function inputs are just the bits of the registered index.
   assign X = M[3];
   assign Y = M[2];
   assign W = M[1];
   assign Z = M[0];

   // Expected S at this index is the complement of the maxterm bit.
   assign miss = S ^ ~mask[M];

   // Sweep sequencer: settle, sample, advance; results latched per index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         mask       <= '0;
         M          <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         table_out  <= '0;
         mismatch   <= '0;
         err_cnt    <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mask       <= exp_maxterms;
                  table_out  <= '0;
                  mismatch   <= '0;
                  err_cnt    <= '0;
                  pass       <= 1'b0;
                  M          <= '0;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= FIRST_STATE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt <= 4'd1) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               table_out[M] <= S;
               mismatch[M]  <= miss;
               err_cnt      <= err_cnt + {4'b0000, miss};
               if (M == 4'd15) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  M          <= M + 4'd1;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= FIRST_STATE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               pass  <= (err_cnt == 5'd0);
               M     <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
